fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined core.
- Keeps an internal shift-register shadow of in-flight destination writes over DEPTH post-issue stages.
- Produces registered per-source forward selects for NUM_SRC operands and a load-use stall.
- Sits beside the ID/EX register. Takes decode-stage operands, drives the EX-stage operand muxes, and supersedes fixed two-stage, single-operand forwarding logic.

Parameters:
- NUM_SRC, 2, number of source-operand channels (rs1, rs2, ...).
- DEPTH, 3, tracked producer stages; entry 1 = EX/MEM ... entry DEPTH = oldest.
- REG_AW, 5, register-index width.
- LOAD_LAT, 1, entries 1..LOAD_LAT holding a load have no data yet; matching them forces a stall.
- SELW, $clog2(DEPTH+1), width of one select field.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- advance, in, 1: pipeline enable; shadow and select registers update only when high.
- flush, in, 1: kill the instruction in ID and the youngest entry.
- issue_wr, in, 1: instruction in ID writes a register.
- issue_rd, in, REG_AW: destination register of the instruction in ID.
- issue_is_load, in, 1: instruction in ID is a load.
- issue_no_fwd, in, 1: instruction in ID ignores forwarding (jal class).
- id_rs, in, NUM_SRC*REG_AW: source indices, channel i at [i*REG_AW +: REG_AW].
- id_rs_used, in, NUM_SRC: per-channel source-valid.
- stall, out, 1: load-use stall (combinational).
- fwd_sel, out, NUM_SRC*SELW: registered selects; 0 = register file, k = entry k.
- stall_count, out, 32: perf counter (see Optional Feature).
- fwd_count, out, 32: perf counter (see Optional Feature).

Behaviour:
- Reset: all shadow entries invalid, fwd_sel = 0, counters = 0. rst has priority over advance and flush.
- Each entry holds {valid, wr, rd, is_load}.
- When advance=1, entry k takes entry k-1 for k = 2..DEPTH, and entry DEPTH falls off.
- When advance=1 and stall=0 and flush=0, entry 1 takes the ID instruction. Otherwise entry 1 becomes a bubble (valid=0).
- When advance=0, everything holds. stall is still computed.
- Match rule for channel i against entry k: valid & wr & rd != 0 & rd == rs_i & id_rs_used[i].
- Select: youngest match wins (lowest k). No match, issue_no_fwd=1, or rs_i == 0 gives 0.
- stall = OR over channels of: youngest match is at k <= LOAD_LAT and that entry is_load.
- A load match hidden behind a younger non-load match does not stall.
- fwd_sel registers on advance=1. Its value is computed in ID and presented with the instruction in EX, so latency is one cycle.
- Registered value on advance: if stall=1 or flush=1, fwd_sel registers 0 (bubble). Otherwise it registers the computed selects.
- flush=1 invalidates entry 1 in the same cycle, even if advance=0, and takes priority over the normal update.
- Simultaneous flush and stall: flush wins; no stall-count increment.
- Wrap and saturation: counters wrap modulo 2^32.

Optional Feature:
- Macro FWD_SCOREBOARD_PERF_EN.
- Defined: stall_count increments each cycle with advance & stall & !flush. fwd_count increments by the number of channels with a nonzero computed select on each non-stalled advance.
- Undefined: both ports are tied to 0, no counter flops are inferred, and behaviour is otherwise identical.

Decomposition:
- Shared include fwd_defs.vh, alongside opcodes.v, holds:
  - select encoding constant FWD_SEL_RF = 0;
  - entry field offsets;
  - REG_ZERO index.
- One natural sub-module, fwd_match: per-channel priority comparator over the DEPTH entries. It outputs sel and load_hazard and is instantiated NUM_SRC times via generate.

Test Plan:
- Reset: rst=1 for 2 cycles, then advance=1 with id_rs={x2,x1} used -> fwd_sel=0, stall=0, counters 0.
- Priority: issue add x5 then sub x5, then an instruction reading rs1=x5 -> registered sel ch0=1 (youngest), not 2. With the sub slot replaced by a bubble, sel=2.
- x0 and no-forward: issue writes to x0, then a reader of x0 -> sel 0. A reader of x7 behind a write of x7 with issue_no_fwd=1 -> sel 0.
- Load-use:
  - lw x3 then add x4,x3,x3 with LOAD_LAT=1 -> stall=1 for exactly one cycle.
  - One bubble enters entry 1; next cycle both selects = 2, stall=0.
  - stall_count=1 with FWD_SCOREBOARD_PERF_EN.
- Flush/hold:
  - lw x3 in entry 1, reader in ID, flush=1 -> entry 1 invalid, no stall next cycle, fwd_sel=0.
  - advance=0 for 3 cycles -> selects and entries unchanged.
- Parameter sweep: NUM_SRC=3, DEPTH=4, LOAD_LAT=2. Producers of x9 at entries 2 and 4, reader of x9 on ch2 -> sel ch2=2. A load at entry 2 matching -> stall=1.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants for the forwarding scoreboard.
// Select encoding and the architectural zero register.
package fwd_scoreboard_pkg;
  localparam int FWD_SEL_RF = 0;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-side request / EX-side select bundle for fwd_scoreboard.
// master = pipeline control, slave = scoreboard.
interface fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int SELW    = 2
);
  logic                      advance;
  logic                      flush;
  logic                      issue_wr;
  logic [REG_AW-1:0]         issue_rd;
  logic                      issue_is_load;
  logic                      issue_no_fwd;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic [31:0]               stall_count;
  logic [31:0]               fwd_count;

  modport master (
    output advance, flush, issue_wr, issue_rd,
    output issue_is_load, issue_no_fwd,
    output id_rs, id_rs_used,
    input  stall, fwd_sel, stall_count, fwd_count
  );

  modport slave (
    input  advance, flush, issue_wr, issue_rd,
    input  issue_is_load, issue_no_fwd,
    input  id_rs, id_rs_used,
    output stall, fwd_sel, stall_count, fwd_count
  );
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Per-channel priority comparator over the shadow entries.
// Index 0 is entry 1 (youngest); the lowest matching index wins.
module fwd_scoreboard_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = 2
) (
  input  logic [REG_AW-1:0]       rs_i,
  input  logic                    used_i,
  input  logic                    no_fwd_i,
  input  logic [DEPTH-1:0]        vld_i,
  input  logic [DEPTH-1:0]        wr_i,
  input  logic [DEPTH-1:0]        ld_i,
  input  logic [DEPTH*REG_AW-1:0] rd_i,
  output logic [SELW-1:0]         sel_o,
  output logic                    load_hazard_o
);
  logic [SELW-1:0] sel_d;
  logic            haz_d;
  logic [REG_AW-1:0] rd_k;

  always_comb begin
    sel_d = SELW'(FWD_SEL_RF);
    haz_d = 1'b0;
    rd_k  = '0;
    // walk oldest to youngest so the youngest match overwrites
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rd_k = rd_i[k*REG_AW +: REG_AW];
      if (vld_i[k] && wr_i[k] && used_i &&
          rd_k != REG_AW'(REG_ZERO) && rd_k == rs_i) begin
        sel_d = SELW'(k + 1);
        haz_d = (k < LOAD_LAT) && ld_i[k];
      end
    end
  end

  assign sel_o         = no_fwd_i ? SELW'(FWD_SEL_RF) : sel_d;
  assign load_hazard_o = haz_d;
endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard scoreboard beside the ID/EX register.
// FWD_SCOREBOARD_PERF_EN enables the stall and forward perf counters.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0]        wr_q, wr_d;
  logic [DEPTH-1:0]        ld_q, ld_d;
  logic [DEPTH*REG_AW-1:0] rd_q, rd_d;
  logic [NUM_SRC*SELW-1:0] sel_q, sel_d;
  logic [NUM_SRC*SELW-1:0] sel_c;
  logic [NUM_SRC-1:0]      haz;
  logic                    stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    fwd_scoreboard_match #(
      .DEPTH   (DEPTH),
      .REG_AW  (REG_AW),
      .LOAD_LAT(LOAD_LAT),
      .SELW    (SELW)
    ) u_match (
      .rs_i         (bus.id_rs[i*REG_AW +: REG_AW]),
      .used_i       (bus.id_rs_used[i]),
      .no_fwd_i     (bus.issue_no_fwd),
      .vld_i        (vld_q),
      .wr_i         (wr_q),
      .ld_i         (ld_q),
      .rd_i         (rd_q),
      .sel_o        (sel_c[i*SELW +: SELW]),
      .load_hazard_o(haz[i])
    );
  end

  assign stall = |haz;

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    sel_d = sel_q;
    if (bus.advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        vld_d[k] = vld_q[k-1];
        wr_d[k]  = wr_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k*REG_AW +: REG_AW] = rd_q[(k-1)*REG_AW +: REG_AW];
      end
      vld_d[0]          = !stall && !bus.flush;
      wr_d[0]           = bus.issue_wr;
      ld_d[0]           = bus.issue_is_load;
      rd_d[0 +: REG_AW] = bus.issue_rd;
      sel_d = (stall || bus.flush) ? '0 : sel_c;
    end else if (bus.flush) begin
      vld_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      sel_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      sel_q <= sel_d;
    end
  end

  assign bus.stall   = stall;
  assign bus.fwd_sel = sel_q;

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [31:0] nfwd;

  always_comb begin
    nfwd = '0;
    for (int i = 0; i < NUM_SRC; i++)
      nfwd = nfwd + 32'(sel_c[i*SELW +: SELW] != '0);
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (bus.advance && stall && !bus.flush)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.advance && !stall)
      fwd_cnt_d = fwd_cnt_q + nfwd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.fwd_count   = fwd_cnt_q;
`else
  assign bus.stall_count = '0;
  assign bus.fwd_count   = '0;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default and swept parameter sets.
// Expected values are hand-computed per scenario.
module tb_fwd_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.NUM_SRC(2), .REG_AW(5), .SELW(2)) a ();
  fwd_scoreboard_if #(.NUM_SRC(3), .REG_AW(5), .SELW(3)) b ();

  fwd_scoreboard #(
    .NUM_SRC(2), .DEPTH(3), .REG_AW(5), .LOAD_LAT(1), .SELW(2)
  ) u_a (
    .clk(clk), .rst(rst), .bus(a)
  );

  fwd_scoreboard #(
    .NUM_SRC(3), .DEPTH(4), .REG_AW(5), .LOAD_LAT(2), .SELW(3)
  ) u_b (
    .clk(clk), .rst(rst), .bus(b)
  );

`ifdef FWD_SCOREBOARD_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a.advance       = 1'b1;
    a.flush         = 1'b0;
    a.issue_wr      = 1'b0;
    a.issue_rd      = '0;
    a.issue_is_load = 1'b0;
    a.issue_no_fwd  = 1'b0;
    a.id_rs         = '0;
    a.id_rs_used    = '0;
  endtask

  task automatic idle_b();
    b.advance       = 1'b1;
    b.flush         = 1'b0;
    b.issue_wr      = 1'b0;
    b.issue_rd      = '0;
    b.issue_is_load = 1'b0;
    b.issue_no_fwd  = 1'b0;
    b.id_rs         = '0;
    b.id_rs_used    = '0;
  endtask

  task automatic iss_a(input logic [4:0] rd, input logic ld);
    idle_a();
    a.issue_wr      = 1'b1;
    a.issue_rd      = rd;
    a.issue_is_load = ld;
  endtask

  task automatic iss_b(input logic [4:0] rd, input logic ld);
    idle_b();
    b.issue_wr      = 1'b1;
    b.issue_rd      = rd;
    b.issue_is_load = ld;
  endtask

  task automatic rd_a(input logic [4:0] rs1, input logic [4:0] rs0,
                      input logic [1:0] used);
    a.id_rs      = {rs1, rs0};
    a.id_rs_used = used;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_a();
    idle_b();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (a.fwd_sel !== 4'b0 || b.fwd_sel !== 9'b0) begin
      fails++;
      $display("FAIL reset_sel: got %b/%b expected 0", a.fwd_sel, b.fwd_sel);
    end
    total++;
    if (a.stall_count !== 32'd0 || a.fwd_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0",
               a.stall_count, a.fwd_count);
    end
    rd_a(5'd2, 5'd1, 2'b11);
    #1;
    total++;
    if (a.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall: got %b expected 0", a.stall);
    end
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL reset_adv_sel: got %b expected 0000", a.fwd_sel);
    end
  endtask

  task automatic test_priority();
    do_reset();
    iss_a(5'd5, 1'b0);
    tick();
    iss_a(5'd5, 1'b0);
    tick();
    idle_a();
    rd_a(5'd0, 5'd5, 2'b01);
    tick();
    total++;
    if (a.fwd_sel !== 4'b0001) begin
      fails++;
      $display("FAIL prio_youngest: got %b expected 0001", a.fwd_sel);
    end
    do_reset();
    iss_a(5'd5, 1'b0);
    tick();
    idle_a();
    tick();
    rd_a(5'd0, 5'd5, 2'b01);
    tick();
    total++;
    if (a.fwd_sel !== 4'b0010) begin
      fails++;
      $display("FAIL prio_bubble: got %b expected 0010", a.fwd_sel);
    end
  endtask

  task automatic test_x0_nofwd();
    do_reset();
    iss_a(5'd0, 1'b0);
    tick();
    idle_a();
    rd_a(5'd0, 5'd0, 2'b11);
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL x0_sel: got %b expected 0000", a.fwd_sel);
    end
    iss_a(5'd7, 1'b0);
    tick();
    idle_a();
    rd_a(5'd7, 5'd7, 2'b11);
    a.issue_no_fwd = 1'b1;
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL nofwd_sel: got %b expected 0000", a.fwd_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    iss_a(5'd3, 1'b1);
    tick();
    iss_a(5'd4, 1'b0);
    rd_a(5'd3, 5'd3, 2'b11);
    #1;
    total++;
    if (a.stall !== 1'b1) begin
      fails++;
      $display("FAIL lu_stall: got %b expected 1", a.stall);
    end
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL lu_bubble_sel: got %b expected 0000", a.fwd_sel);
    end
    total++;
    if (a.stall !== 1'b0) begin
      fails++;
      $display("FAIL lu_stall_once: got %b expected 0", a.stall);
    end
    tick();
    total++;
    if (a.fwd_sel !== 4'b1010) begin
      fails++;
      $display("FAIL lu_sel2: got %b expected 1010", a.fwd_sel);
    end
    total++;
    if (a.stall_count !== 32'(PERF)) begin
      fails++;
      $display("FAIL lu_stall_cnt: got %0d expected %0d",
               a.stall_count, PERF);
    end
    total++;
    if (a.fwd_count !== 32'(2 * PERF)) begin
      fails++;
      $display("FAIL lu_fwd_cnt: got %0d expected %0d",
               a.fwd_count, 2 * PERF);
    end
  endtask

  task automatic test_hold();
    iss_a(5'd9, 1'b0);
    a.advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (a.fwd_sel !== 4'b1010) begin
        fails++;
        $display("FAIL hold_sel%0d: got %b expected 1010", i, a.fwd_sel);
      end
    end
    idle_a();
    rd_a(5'd3, 5'd4, 2'b11);
    tick();
    total++;
    if (a.fwd_sel !== 4'b1101) begin
      fails++;
      $display("FAIL hold_entries: got %b expected 1101", a.fwd_sel);
    end
  endtask

  task automatic test_flush();
    do_reset();
    iss_a(5'd3, 1'b1);
    tick();
    idle_a();
    rd_a(5'd0, 5'd3, 2'b01);
    a.flush = 1'b1;
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL flush_sel: got %b expected 0000", a.fwd_sel);
    end
    total++;
    if (a.stall_count !== 32'd0) begin
      fails++;
      $display("FAIL flush_stall_cnt: got %0d expected 0", a.stall_count);
    end
    a.flush = 1'b0;
    #1;
    total++;
    if (a.stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_next_stall: got %b expected 0", a.stall);
    end
    do_reset();
    iss_a(5'd3, 1'b1);
    tick();
    idle_a();
    a.advance = 1'b0;
    a.flush   = 1'b1;
    tick();
    idle_a();
    rd_a(5'd0, 5'd3, 2'b01);
    #1;
    total++;
    if (a.stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_hold_stall: got %b expected 0", a.stall);
    end
    tick();
    total++;
    if (a.fwd_sel !== 4'b0) begin
      fails++;
      $display("FAIL flush_hold_sel: got %b expected 0000", a.fwd_sel);
    end
  endtask

  task automatic test_hidden_load();
    do_reset();
    iss_a(5'd3, 1'b1);
    tick();
    iss_a(5'd3, 1'b0);
    tick();
    idle_a();
    rd_a(5'd0, 5'd3, 2'b01);
    #1;
    total++;
    if (a.stall !== 1'b0) begin
      fails++;
      $display("FAIL hidden_stall: got %b expected 0", a.stall);
    end
    tick();
    total++;
    if (a.fwd_sel !== 4'b0001) begin
      fails++;
      $display("FAIL hidden_sel: got %b expected 0001", a.fwd_sel);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    iss_b(5'd9, 1'b0);
    tick();
    iss_b(5'd1, 1'b0);
    tick();
    iss_b(5'd9, 1'b0);
    tick();
    iss_b(5'd2, 1'b0);
    tick();
    idle_b();
    b.id_rs      = {5'd9, 10'd0};
    b.id_rs_used = 3'b100;
    #1;
    total++;
    if (b.stall !== 1'b0) begin
      fails++;
      $display("FAIL sweep_nostall: got %b expected 0", b.stall);
    end
    tick();
    total++;
    if (b.fwd_sel !== 9'b010_000_000) begin
      fails++;
      $display("FAIL sweep_sel: got %b expected 010000000", b.fwd_sel);
    end
    do_reset();
    iss_b(5'd9, 1'b1);
    tick();
    iss_b(5'd2, 1'b0);
    tick();
    idle_b();
    b.id_rs      = {5'd9, 10'd0};
    b.id_rs_used = 3'b100;
    #1;
    total++;
    if (b.stall !== 1'b1) begin
      fails++;
      $display("FAIL sweep_load_stall: got %b expected 1", b.stall);
    end
    tick();
    total++;
    if (b.fwd_sel !== 9'b0) begin
      fails++;
      $display("FAIL sweep_load_sel: got %b expected 0", b.fwd_sel);
    end
  endtask

  initial begin
    idle_a();
    idle_b();
    test_reset();
    test_priority();
    test_x0_nofwd();
    test_load_use();
    test_hold();
    test_flush();
    test_hidden_load();
    test_sweep();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
